wb_bram_ctrl: RTL
=================

# wb_bram_ctrl

Wishbone slave controller that sits directly upstream of the 16-bit dual-byte-lane block RAM (15-bit word address, byte write enables, one-cycle registered read). It translates Wishbone classic cycles from the DCPU16 bus into RAM write-enable, address and data strobes. It also generates `wb_ack_o` so that read data arrives on the acked cycle. Optionally it sustains one word per cycle on Wishbone incrementing bursts.

## Interface
- `AW`, 15: word-address width; the RAM holds 2^AW 16-bit words.
- `wb_clk_i` in 1: the single clock; also drives the RAM clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `wb_cyc_i` in 1: bus cycle valid.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_sel_i` in 2: byte lane select; [1] = bits 15:8, [0] = bits 7:0.
- `wb_adr_i` in AW: word address.
- `wb_dat_i` in 16: write data.
- `wb_cti_i` in 3: cycle type identifier (used only with the burst feature).
- `wb_bte_i` in 2: burst type extension (used only with the burst feature).
- `wb_dat_o` out 16: read data.
- `wb_ack_o` out 1: acknowledge.
- `bram_we_o` out 2: per-byte write enable to the RAM.
- `bram_adr_o` out AW: RAM address.
- `bram_dat_o` out 16: RAM write data.
- `bram_dat_i` in 16: RAM read data; registered inside the RAM, valid one clock after the address.

## Operation
- `req` = `wb_cyc_i & wb_stb_i`.
- State machine, two states:
  - IDLE: `ack_q` = 0.
  - ACK: `ack_q` = 1.
- Transitions:
  - IDLE -> ACK when `req`.
  - ACK -> IDLE when `!req`, or when the cycle is not a continuing burst (see Configuration).
  - ACK -> ACK only for a continuing burst.
- `wb_ack_o` = `ack_q & req`. Ack is never driven outside an active cycle.
- Writes take effect only on acked cycles:
  - `bram_we_o` = `wb_sel_i` when `wb_ack_o & wb_we_i`, else 2'b00.
  - `bram_dat_o` = `wb_dat_i` (pass-through).
  - A `wb_sel_i` of 2'b00 acks but writes nothing.
- Reads: `bram_adr_o` presents the address in the request cycle. The RAM registers the data. `wb_dat_o` = `bram_dat_i` when `wb_ack_o` and a read is in progress, else 16'h0000.
- Address select:
  - `bram_adr_o` = `next_adr` when in ACK, reading, and in a continuing burst.
  - Otherwise `bram_adr_o` = `wb_adr_i`.
- `next_adr` per `wb_bte_i`:
  - 00: linear +1, modulo 2^AW.
  - 01: low 2 bits increment and wrap, upper bits held.
  - 10: low 3 bits increment and wrap.
  - 11: low 4 bits increment and wrap.
- Reset values: `wb_ack_o` 0, `wb_dat_o` 16'h0000, `bram_we_o` 2'b00, state IDLE.
- `bram_adr_o` and `bram_dat_o` are combinational from the inputs.
- Reset mid-cycle or mid-burst: state returns to IDLE immediately. `wb_ack_o` and `bram_we_o` fall in the same cycle and no write occurs.
- `wb_cyc_i` or `wb_stb_i` dropped while in ACK: ack is suppressed in that cycle and the next state is IDLE.
- `wb_we_i` changing inside a burst is a master protocol violation; behaviour is undefined.

## Timing
- Single access: request seen in cycle T, ack in cycle T+1. For reads, data is valid in T+1. For writes, the RAM is written on the edge that ends T+1.
- After each non-burst ack, the controller spends one IDLE cycle. A classic access therefore occupies 2 cycles, and back-to-back requests ack every other cycle.
- Burst (feature enabled): first ack at T+1, then one ack per cycle until termination. An N-word burst takes N+1 cycles.
- A cycle with `wb_cti_i` = 3'b111 is acked, then the next state is IDLE.

## Configuration
- `WB_BRAM_BURST_EN` defined:
  - A continuing burst is `req & wb_cti_i == 3'b010`.
  - Reads prefetch `next_adr` so every cycle is acked.
  - Burst writes are acked every cycle, each writing `wb_adr_i`.
- `WB_BRAM_BURST_EN` undefined:
  - `wb_cti_i` and `wb_bte_i` are ignored.
  - Every access is classic: IDLE -> ACK -> IDLE.
  - `bram_adr_o` is always `wb_adr_i`.

## Test plan
- Full write, then read:
  - Write `wb_sel_i` = 2'b11, addr 0x0010, data 0xBEEF -> `wb_ack_o` is high exactly 1 cycle, 1 cycle after the strobe.
  - Read 0x0010 -> `wb_dat_o` = 0xBEEF on the ack cycle, 0x0000 otherwise.
- Byte-lane write: write `wb_sel_i` = 2'b01, data 0x0012, to 0x0010. Readback = 0xBE12. Then `wb_sel_i` = 2'b00 with data 0xFFFF -> acked, readback still 0xBE12.
- Back-to-back classic reads: 0x0001 then 0x0002 with strobe held -> ack pattern 0,1,0,1 with the correct data on each ack.
- Linear burst (macro on): read from 0x7FFE, `wb_cti_i` = 010 ×3 then 111, `wb_bte_i` = 00 -> 4 consecutive acks returning words 0x7FFE, 0x7FFF, 0x0000, 0x0001, then ack low.
- Wrap-4 burst (macro on): start 0x0006 -> addresses 6, 7, 4, 5.
  - With the macro off, the same stimulus -> acks every other cycle.
- Reset mid-burst write: assert `wb_rst_i` on the 2nd data beat -> `wb_ack_o` and `bram_we_o` low in the same cycle, target word unchanged, state IDLE after release.

Source files
------------

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave driving a 16-bit dual-byte-lane block RAM with registered read.
// Define WB_BRAM_BURST_EN to sustain one ack per cycle on incrementing bursts (cti 3'b010).
module wb_bram_ctrl #(
  parameter int AW = 15
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [1:0]    wb_sel_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [15:0]   wb_dat_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [15:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic [1:0]    bram_we_o,
  output logic [AW-1:0] bram_adr_o,
  output logic [15:0]   bram_dat_o,
  input  logic [15:0]   bram_dat_i
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  logic [0:0] state_q, state_d;
  logic       req;
  logic       burstCont;
  logic       ackOut;

  assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_BRAM_BURST_EN
  logic [AW-1:0] nextAdr;

  assign burstCont = req & (wb_cti_i == 3'b010);

  always_comb begin
    nextAdr = wb_adr_i + AW'(1);
    case (wb_bte_i)
      2'b01:   nextAdr = {wb_adr_i[AW-1:2], wb_adr_i[1:0] + 2'd1};
      2'b10:   nextAdr = {wb_adr_i[AW-1:3], wb_adr_i[2:0] + 3'd1};
      2'b11:   nextAdr = {wb_adr_i[AW-1:4], wb_adr_i[3:0] + 4'd1};
      default: nextAdr = wb_adr_i + AW'(1);
    endcase
  end

  // Reads prefetch the following beat so the RAM's one-cycle read latency stays hidden.
  assign bram_adr_o = (state_q == ACK && !wb_we_i && burstCont) ? nextAdr : wb_adr_i;
`else
  logic unusedBurstIn;

  assign unusedBurstIn = ^{wb_cti_i, wb_bte_i};
  assign burstCont     = 1'b0;
  assign bram_adr_o    = wb_adr_i;
`endif

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = req ? ACK : IDLE;
      ACK:     state_d = burstCont ? ACK : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack is gated by req so a master dropping cyc/stb never sees a stray ack.
  assign ackOut     = (state_q == ACK) & req;
  assign wb_ack_o   = ackOut;
  assign bram_we_o  = (ackOut & wb_we_i) ? wb_sel_i : 2'b00;
  assign bram_dat_o = wb_dat_i;
  assign wb_dat_o   = (ackOut & !wb_we_i) ? bram_dat_i : 16'h0000;

endmodule
